cgra0_out_arbiter: RTL and testbench
====================================

Name: cgra0_out_arbiter

Overview:
- Round-robin arbiter that lets NUM_OUT output-PE FIFOs share one downstream write channel to the accelerator output memory.
- Each requester presents a FIFO with a 1-cycle registered read latency: data is valid the cycle after re.
- The arbiter drains a granted FIFO in bursts of up to BURST words, tags each word with the source index, and reports global completion once every stream is done and drained.

Parameters:
- NUM_OUT, 4, number of output-PE FIFO requesters (2..16).
- DATA_WIDTH, 16, word width, matching PE fifo_data.
- ID_WIDTH, 2, width of the source tag; must satisfy 2^ID_WIDTH >= NUM_OUT.
- BURST, 8, maximum words drained per grant (>=1).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-low.
- en  input  1  global enable; gates new grants and FIFO reads.
- req_empty  input  NUM_OUT  per-requester FIFO empty flag.
- req_done  input  NUM_OUT  per-requester stream finished (no further pushes).
- req_data  input  NUM_OUT*DATA_WIDTH  FIFO read data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_re  output  NUM_OUT  one-hot FIFO read strobe.
- wr_valid  output  1  downstream word valid.
- wr_ready  input  1  downstream accept.
- wr_data  output  DATA_WIDTH  downstream word.
- wr_id  output  ID_WIDTH  source requester index of wr_data.
- wr_last  output  1  final word of the current burst.
- all_done  output  1  all streams done and all FIFOs empty; registered.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state=IDLE, rr_ptr=0, burst_cnt=0.
  - req_re=0, wr_valid=0, wr_data=0, wr_id=0, wr_last=0, all_done=0.
- FSM states: IDLE, FETCH, SEND.
- IDLE:
  - If en=1 and some req_empty[i]=0, grant g = first non-empty index searching from rr_ptr upward, wrapping NUM_OUT-1 -> 0.
  - In the same cycle: assert req_re[g], set burst_cnt=1, latch g, go to FETCH.
  - Otherwise stay in IDLE with req_re=0.
- FETCH:
  - Register req_data slice g into wr_data, set wr_id=g, wr_valid=1.
  - wr_last = (burst_cnt==BURST) or (req_empty[g]=1 sampled this cycle).
  - Go to SEND.
- SEND:
  - wr_valid, wr_data, wr_id and wr_last hold stable until wr_ready=1, independent of en.
  - On handshake with wr_last=0 and en=1: assert req_re[g], increment burst_cnt, go to FETCH. Sustained rate is 1 word per 2 cycles.
  - On handshake with wr_last=1: clear wr_valid, set rr_ptr=(g+1) mod NUM_OUT, go to IDLE.
  - On handshake with wr_last=0 and en=0: clear wr_valid, stay in SEND-paused until en=1, then issue req_re[g] and continue the burst. Grant is retained.
- req_re is never asserted for a FIFO whose req_empty=1 in that cycle. req_re is at most one-hot, and at most one read is outstanding at a time.
- A FIFO emptying mid-burst ends the burst early via wr_last. A refill afterwards waits for its next round-robin turn.
- A single non-empty requester is granted back-to-back, with one IDLE cycle between bursts.
- all_done:
  - Next value = &req_done & ~|req_empty_n & (state==IDLE) & ~wr_valid, where req_empty_n = ~req_empty.
  - Sticky until reset.
- wr_id is zero-extended when ID_WIDTH > clog2(NUM_OUT).

Optional Feature:
- Macro: CGRA0_OUT_ARB_STATS_EN.
- Defined:
  - Adds inputs stat_sel (ID_WIDTH) and outputs stat_cnt (32).
  - One 32-bit counter per requester increments on each handshake with wr_id=i and wraps at 2^32.
  - stat_cnt = counter[stat_sel], combinational; counters are reset to 0.
- Undefined: no stat ports and no counters; behaviour is otherwise identical.

Decomposition:
- Shared package/header cgra0_out_arb_pkg holds:
  - state encoding localparams S_IDLE=2'd0, S_FETCH=2'd1, S_SEND=2'd2, S_PAUSE=2'd3.
  - the stats counter width constant (32).
- Sub-module rr_arbiter (parameter N):
  - inputs req[N] and ptr; outputs one-hot gnt and gnt_idx.
  - purely combinational, reused for the IDLE grant.

Test Plan:
- Single requester 0 holding 3 words (A,B,C), wr_ready=1: req_re[0] pulses 3 times; words A,B,C with wr_id=0; wr_last only on C; back to IDLE; rr_ptr=1.
- All 4 FIFOs each hold 10 words, BURST=8: grant order 0,1,2,3,0,1,2,3; bursts of 8 words then 2 words per requester, wr_last on the 8th and 10th words; 40 words total.
- wr_ready held low 5 cycles during SEND: wr_data, wr_id and wr_valid stay constant; no req_re; resumes on wr_ready=1.
- en dropped mid-burst after the 3rd handshake: no req_re while en=0; the 4th word follows within 2 cycles of en=1 with the same wr_id.
- FIFOs 1 and 3 only, rr_ptr=2: first grant 3, then 1; req_re is never asserted for empty 0 or 2.
- All req_done=1 and FIFOs drained: all_done rises 1 cycle after the final handshake; an async rst pulse mid-SEND clears wr_valid and all_done immediately.

Source files
------------

// File: rtl/cgra0_out_arb_pkg.sv
// Shared definitions for the CGRA output arbiter: FSM state encoding and
// the width of the optional per-requester word counters.
package cgra0_out_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_PAUSE = 2'd3
    } arb_state_e;

    localparam int STAT_CNT_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping N-1 -> 0. Produces a one-hot grant and its index.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic         found_s;
    logic [W-1:0] idx_s;

    // Rotating priority search starting at ptr
    always_comb begin
        found_s = 1'b0;
        idx_s   = '0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            idx_s = W'((int'(ptr) + k) % N);
            if (!found_s && req[idx_s]) begin
                found_s = 1'b1;
                gnt_idx = idx_s;
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            gnt = N'(1'b1) << gnt_idx;
        end else begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/cgra0_out_arbiter.sv
// Round-robin burst arbiter draining NUM_OUT 1-cycle-latency FIFOs into one
// tagged write channel. Optional counters: define CGRA0_OUT_ARB_STATS_EN.
module cgra0_out_arbiter
    import cgra0_out_arb_pkg::*;
#(
    parameter int NUM_OUT    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 2,
    parameter int BURST      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_OUT-1:0]            req_empty,
    input  logic [NUM_OUT-1:0]            req_done,
    input  logic [NUM_OUT*DATA_WIDTH-1:0] req_data,
    output logic [NUM_OUT-1:0]            req_re,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [ID_WIDTH-1:0]           wr_id,
    output logic                          wr_last,
    output logic                          all_done
`ifdef CGRA0_OUT_ARB_STATS_EN
    ,
    input  logic [ID_WIDTH-1:0]           stat_sel,
    output logic [STAT_CNT_W-1:0]         stat_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_OUT);
    localparam int CNT_W = $clog2(BURST + 1);

    arb_state_e              state_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [IDX_W-1:0]        rr_ptr_d;
    logic [IDX_W-1:0]        gnt_q;
    logic [CNT_W-1:0]        burst_cnt_q;
    logic                    wr_valid_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic [ID_WIDTH-1:0]     wr_id_q;
    logic                    wr_last_q;
    logic                    all_done_q;
    logic                    all_done_d;

    logic [NUM_OUT-1:0]      req_avail_s;
    logic [NUM_OUT-1:0]      arb_gnt_s;
    logic [IDX_W-1:0]        arb_idx_s;
    logic                    hs_s;
    logic                    start_s;
    logic                    cont_s;

    assign req_avail_s = ~req_empty;
    assign hs_s        = wr_valid_q & wr_ready;
    assign start_s     = (state_q == S_IDLE) & en & (|req_avail_s);
    // A read continues the burst either right at the handshake or on leaving pause
    assign cont_s      = ((state_q == S_SEND) & hs_s & ~wr_last_q & en)
                       | ((state_q == S_PAUSE) & en);
    assign rr_ptr_d    = (gnt_q == IDX_W'(NUM_OUT - 1)) ? '0 : gnt_q + 1'b1;
    assign all_done_d  = all_done_q
                       | ((&req_done) & (&req_empty) & (state_q == S_IDLE) & ~wr_valid_q);

    rr_arbiter #(.N(NUM_OUT)) u_rr (
        .req     (req_avail_s),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt_s),
        .gnt_idx (arb_idx_s)
    );

    // Read strobe must be same-cycle so FIFO data lands during FETCH
    always_comb begin
        req_re = '0;
        if (start_s) begin
            req_re = arb_gnt_s;
        end else if (cont_s) begin
            req_re = NUM_OUT'(1'b1) << gnt_q;
        end else begin
            req_re = '0;
        end
    end

    // Grant / burst FSM with registered write-channel outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            burst_cnt_q <= '0;
            wr_valid_q  <= 1'b0;
            wr_data_q   <= '0;
            wr_id_q     <= '0;
            wr_last_q   <= 1'b0;
            all_done_q  <= 1'b0;
        end else begin
            all_done_q <= all_done_d;
            case (state_q)
                S_IDLE: begin
                    if (start_s) begin
                        gnt_q       <= arb_idx_s;
                        burst_cnt_q <= CNT_W'(1);
                        state_q     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    wr_data_q  <= req_data[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
                    wr_id_q    <= ID_WIDTH'(gnt_q);
                    wr_valid_q <= 1'b1;
                    wr_last_q  <= (burst_cnt_q == CNT_W'(BURST)) | req_empty[gnt_q];
                    state_q    <= S_SEND;
                end
                S_SEND: begin
                    if (hs_s) begin
                        wr_valid_q <= 1'b0;
                        if (wr_last_q) begin
                            rr_ptr_q <= rr_ptr_d;
                            state_q  <= S_IDLE;
                        end else if (en) begin
                            burst_cnt_q <= burst_cnt_q + 1'b1;
                            state_q     <= S_FETCH;
                        end else begin
                            state_q <= S_PAUSE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (en) begin
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                        state_q     <= S_FETCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_data  = wr_data_q;
    assign wr_id    = wr_id_q;
    assign wr_last  = wr_last_q;
    assign all_done = all_done_q;

`ifdef CGRA0_OUT_ARB_STATS_EN
    logic [STAT_CNT_W-1:0] stat_q [NUM_OUT];

    // Per-source accepted-word counters, wrapping naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (hs_s && (wr_id_q == ID_WIDTH'(i))) begin
                    stat_q[i] <= stat_q[i] + 1'b1;
                end
            end
        end
    end

    // Counter readback mux
    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (stat_sel == ID_WIDTH'(i)) begin
                stat_cnt = stat_q[i];
            end else begin
                stat_cnt = stat_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cgra0_out_arbiter.sv
// Randomized bench for cgra0_out_arbiter: FIFO environment with 1-cycle read
// latency, expected word stream derived from round-robin burst rules.
module tb_cgra0_out_arbiter;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int BURST = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b0;
    logic            wr_ready = 1'b0;
    logic [N-1:0]    req_empty = '1;
    logic [N-1:0]    req_done = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_re;
    logic            wr_valid;
    logic            wr_last;
    logic            all_done;
    logic [DW-1:0]   wr_data;
    logic [1:0]      wr_id;

    always #5 clk = ~clk;

    cgra0_out_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_empty (req_empty),
        .req_done  (req_done),
        .req_data  (req_data),
        .req_re    (req_re),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_id     (wr_id),
        .wr_last   (wr_last),
        .all_done  (all_done)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    id;
        logic          last;
    } exp_t;

    logic [DW-1:0] fq [N][$];
    exp_t          exp_q [$];
    int            n_chk = 0;
    int            n_err = 0;
    int            mptr = 0;
    int            en_pct = 100;
    int            rdy_pct = 100;
    logic          hold_v = 1'b0;
    logic [DW+2:0] hold_s = '0;

    // FIFO environment: registered read data, empty flag follows occupancy
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (req_re[i] && fq[i].size() > 0) begin
                req_data[i*DW +: DW] <= fq[i].pop_front();
            end
            req_empty[i] <= (fq[i].size() == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive random en/ready, then observe and score
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        en       = ($urandom_range(0, 99) < en_pct);
        wr_ready = ($urandom_range(0, 99) < rdy_pct);
        #1;
        if (req_re != '0) begin
            chk("re_ok", {31'd0, ($onehot(req_re) && ((req_re & req_empty) == '0))}, 32'd1);
        end
        if (!en) begin
            chk("re_gated", {28'd0, req_re}, 32'd0);
        end
        if (hold_v) begin
            chk("hold_valid", {31'd0, wr_valid}, 32'd1);
            chk("hold_word", {13'd0, wr_data, wr_id, wr_last}, {13'd0, hold_s});
        end
        hold_v = wr_valid && !wr_ready;
        hold_s = {wr_data, wr_id, wr_last};
        if (wr_valid && wr_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_word", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_data", {16'd0, wr_data}, {16'd0, e.d});
                chk("wr_id", {30'd0, wr_id}, {30'd0, e.id});
                chk("wr_last", {31'd0, wr_last}, {31'd0, e.last});
            end
        end
    endtask

    // Load FIFOs, predict the complete output stream, then run it out
    task automatic run_scn(input int c0, input int c1, input int c2, input int c3,
                           input int rp, input int ep, input bit done_f);
        int            cnt [N];
        int            rem [N];
        logic [DW-1:0] ld [N][$];
        logic [DW-1:0] v;
        int            tot, g, n, j, budget;
        cnt = '{c0, c1, c2, c3};
        rdy_pct = rp;
        en_pct  = ep;
        tot = 0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < cnt[i]; k++) begin
                v = 16'($urandom);
                fq[i].push_back(v);
                ld[i].push_back(v);
            end
            rem[i] = cnt[i];
            tot += cnt[i];
        end
        while (tot > 0) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                j = (mptr + k) % N;
                if (g < 0 && rem[j] > 0) g = j;
            end
            n = (rem[g] < BURST) ? rem[g] : BURST;
            for (int w = 0; w < n; w++) begin
                exp_q.push_back('{d: ld[g].pop_front(), id: 2'(g), last: (w == n - 1)});
            end
            rem[g] -= n;
            tot    -= n;
            mptr = (g + 1) % N;
        end
        step();
        if (done_f) req_done = '1;
        budget = 0;
        while (exp_q.size() > 0 && budget < 3000) begin
            step();
            budget++;
        end
        if (exp_q.size() > 0) begin
            chk("timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        if (done_f) begin
            step();
            chk("done_early", {31'd0, all_done}, 32'd0);
            step();
            chk("done_rise", {31'd0, all_done}, 32'd1);
        end
        rdy_pct = 100;
        en_pct  = 100;
        repeat (4) step();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, wr_valid}, 32'd0);
        chk("rst_data", {16'd0, wr_data}, 32'd0);
        chk("rst_id", {30'd0, wr_id}, 32'd0);
        chk("rst_last", {31'd0, wr_last}, 32'd0);
        chk("rst_done", {31'd0, all_done}, 32'd0);
        chk("rst_re", {28'd0, req_re}, 32'd0);
        #2 rst = 1'b1;

        run_scn(3, 0, 0, 0, 100, 100, 1'b0);
        run_scn(10, 10, 10, 10, 100, 100, 1'b0);
        run_scn(0, 1, 0, 0, 100, 100, 1'b0);
        run_scn(0, 4, 0, 6, 70, 100, 1'b0);
        run_scn(5, 0, 9, 0, 30, 100, 1'b0);
        run_scn(0, 12, 0, 3, 100, 40, 1'b0);
        for (int r = 0; r < 6; r++) begin
            run_scn($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20),
                    $urandom_range(0, 20), 60, 75, 1'b0);
        end
        run_scn($urandom_range(1, 20), $urandom_range(0, 20), $urandom_range(0, 20),
                $urandom_range(0, 20), 70, 80, 1'b1);
        chk("done_sticky", {31'd0, all_done}, 32'd1);

        // Asynchronous reset while a word is stalled on the channel
        rdy_pct = 0;
        en_pct  = 100;
        for (int k = 0; k < 5; k++) fq[0].push_back(16'(16'h1000 + k));
        budget = 0;
        while (!wr_valid && budget < 12) begin
            step();
            budget++;
        end
        chk("pre_rst_valid", {31'd0, wr_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", {31'd0, wr_valid}, 32'd0);
        chk("arst_done", {31'd0, all_done}, 32'd0);
        chk("arst_data", {16'd0, wr_data}, 32'd0);
        en      = 1'b0;
        en_pct  = 0;
        req_done = '0;
        for (int i = 0; i < N; i++) fq[i].delete();
        hold_v = 1'b0;
        mptr   = 0;
        #3 rst = 1'b1;
        repeat (3) step();
        run_scn(2, 0, 3, 0, 80, 90, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
